io_trap_ctrl: RTL and testbench

Parametrised I/O trap controller for the Z80 MegaMapper CPLD, the successor to the single-window mapper trap logic. It compares each Z80 I/O cycle against NUM_WIN programmable base/mask windows and suppresses hits from the system bus. Each hit is logged into a capture FIFO, and the block raises a timed NMI so the trap handler can read the log through the mapper I/O register port.

---
 rtl/io_trap_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_io_trap_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_trap_ctrl.sv
// ---------------------------------------------------------------------------
// io_trap_ctrl
//
// I/O trap controller for the Z80 MegaMapper CPLD. Each Z80 I/O cycle is
// compared against NUM_WIN programmable base/mask windows. A hit is hidden
// from the system bus (iorq_sys_n stays high), logged into a capture FIFO,
// and a timed NMI is raised so the handler can read the log back through
// the mapper register port.
//
// Parameters
//   NUM_WIN     number of trap windows (1..4)
//   FIFO_DEPTH  capture entries, power of two (2..16)
//   NMI_WIDTH   nmi_n low time in clk cycles (1..15)
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   iorq_n/rd_n/wr_n/m1_n  Z80 bus strobes
//   addr[7:0]           I/O port address
//   data_in[7:0]        Z80 data bus (input side)
//   reg_sel             mapper register space decode (never trapped)
//   lo_addr[2:0]        register index
//   data_out[7:0]       register read data
//   data_oe             drive enable for data_out
//   iorq_sys_n          iorq_n gated by trap hit or reg_sel
//   nmi_n               trap NMI
//
// Build option
//   TRAP_CAPTURE_DATA_EN  when defined, write data is stored per entry and
//                         register 2 returns it; otherwise register 2
//                         always reads 0xFF.
// ---------------------------------------------------------------------------
module io_trap_ctrl #(
    parameter int NUM_WIN    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int NMI_WIDTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       reg_sel,
    input  logic [2:0] lo_addr,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       iorq_sys_n,
    output logic       nmi_n
);

    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = PW + 1;
    localparam int unsigned   NWU        = NUM_WIN;
    localparam int unsigned   DEPTHU     = FIFO_DEPTH;
    localparam logic [2:0]    NW3        = 3'(NUM_WIN);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [3:0]    PULSE_LAST = 4'(NMI_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_ARMED = 2'd2
    } nmi_state_t;

    // ---------------------------------------------------------------- bus decode
    logic io_cycle, io_cycle_q, start;
    logic reg_wr, reg_wr_q, reg_wr_start;

    assign io_cycle     = !iorq_n && m1_n && (!rd_n || !wr_n);
    assign start        = io_cycle && !io_cycle_q;
    assign reg_wr       = reg_sel && !iorq_n && !wr_n;
    assign reg_wr_start = reg_wr && !reg_wr_q;

    // ---------------------------------------------------------------- config regs
    logic [7:0]         base [NUM_WIN];
    logic [7:0]         mask [NUM_WIN];
    logic [NUM_WIN-1:0] enable;
    logic [1:0]         ptr;
    logic               overflow;

    // ---------------------------------------------------------------- window match
    logic       hit;
    logic [1:0] hit_win;

    // Ascending scan with a found flag so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_win = '0;
        for (int unsigned i = 0; i < NWU; i++) begin
            if (!hit && enable[i] && (((addr ^ base[i]) & mask[i]) == 8'h00)) begin
                hit     = 1'b1;
                hit_win = 2'(i);
            end
        end
    end

    assign iorq_sys_n = iorq_n || reg_sel || (io_cycle && hit);

    // ---------------------------------------------------------------- capture FIFO
    logic [1:0]    fifo_win  [FIFO_DEPTH];
    logic          fifo_dir  [FIFO_DEPTH];
    logic [7:0]    fifo_addr [FIFO_DEPTH];
`ifdef TRAP_CAPTURE_DATA_EN
    logic [7:0]    fifo_data [FIFO_DEPTH];
`endif
    logic [PW-1:0] head_ptr, tail_ptr;
    logic [CW-1:0] count;
    logic          empty, full, capture, pop, push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign capture = start && hit && !reg_sel;
    assign pop     = reg_wr_start && (lo_addr == 3'd3) && !empty;
    // A pop on the same edge frees the head slot, so a full FIFO still accepts.
    assign push    = capture && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_win[tail_ptr]  <= hit_win;
            fifo_dir[tail_ptr]  <= !wr_n;
            fifo_addr[tail_ptr] <= addr;
`ifdef TRAP_CAPTURE_DATA_EN
            fifo_data[tail_ptr] <= !wr_n ? data_in : 8'hFF;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_cycle_q <= 1'b0;
            reg_wr_q   <= 1'b0;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
        end else begin
            io_cycle_q <= io_cycle;
            reg_wr_q   <= reg_wr;
            if (push) tail_ptr <= tail_ptr + PW'(1);
            if (pop)  head_ptr <= head_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // ---------------------------------------------------------------- register writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            enable   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < NWU; i++) begin
                base[i] <= '0;
                mask[i] <= '0;
            end
        end else begin
            if (capture && full && !pop)
                overflow <= 1'b1;
            else if (reg_wr_start && (lo_addr == 3'd0))
                overflow <= 1'b0;

            if (reg_wr_start) begin
                case (lo_addr)
                    3'd4: if ({1'b0, data_in[1:0]} < NW3) ptr <= data_in[1:0];
                    3'd5: for (int unsigned i = 0; i < NWU; i++)
                              if (ptr == 2'(i)) base[i] <= data_in;
                    3'd6: for (int unsigned i = 0; i < NWU; i++)
                              if (ptr == 2'(i)) mask[i] <= data_in;
                    3'd7: enable <= data_in[NUM_WIN-1:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- register reads
    logic [7:0] sel_base, sel_mask;
    logic [1:0] head_win;
    logic       head_dir;
    logic [7:0] head_addr;
    logic [7:0] head_data;
    logic [7:0] rd_mux;

    always_comb begin
        sel_base = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < NWU; i++) begin
            if (ptr == 2'(i)) begin
                sel_base = base[i];
                sel_mask = mask[i];
            end
        end
    end

    // Head fields are forced to zero while the FIFO is empty.
    always_comb begin
        head_win  = '0;
        head_dir  = 1'b0;
        head_addr = '0;
        head_data = 8'hFF;
`ifdef TRAP_CAPTURE_DATA_EN
        head_data = '0;
`endif
        if (!empty) begin
            head_win  = fifo_win[head_ptr];
            head_dir  = fifo_dir[head_ptr];
            head_addr = fifo_addr[head_ptr];
`ifdef TRAP_CAPTURE_DATA_EN
            head_data = fifo_data[head_ptr];
`endif
        end
    end

    always_comb begin
        rd_mux = '0;
        case (lo_addr)
            3'd0: rd_mux = {!empty, overflow, head_dir, head_win, 3'b000};
            3'd1: rd_mux = head_addr;
            3'd2: rd_mux = head_data;
            3'd3: rd_mux = 8'(count);
            3'd4: rd_mux = {6'b0, ptr};
            3'd5: rd_mux = sel_base;
            3'd6: rd_mux = sel_mask;
            default: rd_mux = 8'(enable);
        endcase
    end

    assign data_out = rd_mux;
    assign data_oe  = reg_sel && !iorq_n && !rd_n;

    // ---------------------------------------------------------------- NMI FSM
    nmi_state_t state;
    logic [3:0] nmi_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            nmi_cnt <= '0;
            nmi_n   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state   <= S_PULSE;
                        nmi_n   <= 1'b0;
                        nmi_cnt <= PULSE_LAST;
                    end
                end
                S_PULSE: begin
                    if (nmi_cnt == '0) begin
                        state <= S_ARMED;
                        nmi_n <= 1'b1;
                    end else begin
                        nmi_cnt <= nmi_cnt - 4'd1;
                    end
                end
                S_ARMED: begin
                    if (empty) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    nmi_n <= 1'b1;
                end
            endcase
        end
    end

    // Keeps the depth parameter referenced in builds where only PW is used.
    logic unused_depth;
    assign unused_depth = (DEPTHU == 0);

endmodule

// File: tb/tb_io_trap_ctrl.sv
`timescale 1ns/1ps
module tb_io_trap_ctrl;

    localparam int NW = 2;
    localparam int D  = 4;
    localparam int W  = 4;
`ifdef TRAP_CAPTURE_DATA_EN
    localparam bit DATA_EN = 1'b1;
`else
    localparam bit DATA_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
    logic [7:0] addr = '0, data_in = '0;
    logic       reg_sel = 1'b0;
    logic [2:0] lo_addr = '0;
    logic [7:0] data_out;
    logic       data_oe, iorq_sys_n, nmi_n;

    io_trap_ctrl #(.NUM_WIN(NW), .FIFO_DEPTH(D), .NMI_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .addr(addr), .data_in(data_in), .reg_sel(reg_sel),
        .lo_addr(lo_addr), .data_out(data_out), .data_oe(data_oe),
        .iorq_sys_n(iorq_sys_n), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------ reference model
    typedef struct packed {
        logic [1:0] win;
        logic       dir;
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  m_base[4];
    logic [7:0]  m_mask[4];
    logic [NW-1:0] m_en = '0;
    logic [1:0]  m_ptr = '0;
    bit          m_ovf = 0;
    bit          m_io_q = 0, m_rw_q = 0;
    int          edge_no = 0, pulse_start = 0;
    bit          in_ep = 0;
    logic        m_nmi_n = 1'b1;

    function automatic int m_hit_idx();
        for (int i = 0; i < NW; i++)
            if (m_en[i] && (((addr ^ m_base[i]) & m_mask[i]) == 8'h00)) return i;
        return -1;
    endfunction

    function automatic logic m_sys();
        bit io;
        io = !iorq_n && m1_n && (!rd_n || !wr_n);
        return iorq_n || reg_sel || (io && (m_hit_idx() >= 0));
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] idx);
        ent_t h;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        case (idx)
            3'd0: return {mq.size() > 0, m_ovf, h.dir, h.win, 3'b000};
            3'd1: return h.a;
            3'd2: return DATA_EN ? h.d : 8'hFF;
            3'd3: return 8'(mq.size());
            3'd4: return {6'b0, m_ptr};
            3'd5: return m_base[m_ptr];
            3'd6: return m_mask[m_ptr];
            default: return 8'(m_en);
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int i = 0; i < 4; i++) begin m_base[i] = '0; m_mask[i] = '0; end
            m_en = '0; m_ptr = '0; m_ovf = 0; m_io_q = 0; m_rw_q = 0;
            in_ep = 0; m_nmi_n = 1'b1;
        end else begin
            bit io, st, rw, rws, ne, full, pop, cap;
            int h;
            io  = !iorq_n && m1_n && (!rd_n || !wr_n);
            st  = io && !m_io_q;
            rw  = reg_sel && !iorq_n && !wr_n;
            rws = rw && !m_rw_q;
            m_io_q = io; m_rw_q = rw;
            edge_no++;
            // NMI: low for W edges starting at the first edge that sees a
            // non-empty log while no episode is open; the episode closes on
            // the first edge after the pulse that sees an empty log.
            ne = mq.size() > 0;
            if (!in_ep && ne) begin in_ep = 1; pulse_start = edge_no; end
            else if (in_ep && edge_no >= pulse_start + W + 1 && !ne) in_ep = 0;
            m_nmi_n = !(in_ep && edge_no <= pulse_start + W - 1);
            h    = m_hit_idx();
            cap  = st && h >= 0 && !reg_sel;
            full = mq.size() == D;
            pop  = rws && lo_addr == 3'd3 && mq.size() > 0;
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (!full || pop) mq.push_back('{win: 2'(h), dir: !wr_n, a: addr,
                                                 d: (!wr_n ? data_in : 8'hFF)});
                else m_ovf = 1;
            end
            if (rws) begin
                case (lo_addr)
                    3'd0: m_ovf = 0;
                    3'd4: if (int'(data_in[1:0]) < NW) m_ptr = data_in[1:0];
                    3'd5: m_base[m_ptr] = data_in;
                    3'd6: m_mask[m_ptr] = data_in;
                    3'd7: m_en = data_in[NW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ bus driver
    logic       obs_sys_pre, exp_sys_pre, obs_sys_post, exp_sys_post;
    logic [7:0] obs_rd, exp_rd;
    logic       obs_oe, exp_oe, obs_nmi, exp_nmi;

    // m1 = 0 produces an interrupt acknowledge (no rd/wr strobe).
    task automatic bus(input bit wr, input bit sel, input bit m1,
                       input logic [7:0] a, input logic [2:0] lo, input logic [7:0] d);
        @(negedge clk);
        addr = a; lo_addr = lo; reg_sel = sel; m1_n = m1; data_in = d; iorq_n = 0;
        if (m1) begin if (wr) wr_n = 0; else rd_n = 0; end
        #1;
        obs_sys_pre = iorq_sys_n; exp_sys_pre = m_sys();
        @(negedge clk);
        obs_sys_post = iorq_sys_n; exp_sys_post = m_sys();
        obs_rd = data_out; exp_rd = m_read(lo);
        obs_oe = data_oe; exp_oe = sel && !wr && m1;
        obs_nmi = nmi_n; exp_nmi = m_nmi_n;
        iorq_n = 1; rd_n = 1; wr_n = 1; reg_sel = 0; m1_n = 1;
    endtask

    task automatic reg_wr(input logic [2:0] idx, input logic [7:0] d);
        bus(1, 1, 1, 8'h00, idx, d);
    endtask
    task automatic reg_rd(input logic [2:0] idx);
        bus(0, 1, 1, 8'h00, idx, 8'($urandom));
    endtask
    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        bus(1, 0, 1, a, 3'd0, d);
    endtask
    task automatic io_rd(input logic [7:0] a);
        bus(0, 0, 1, a, 3'd0, 8'($urandom));
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (nmi_n !== 1'b1) begin n_fail++; $display("FAIL reset_nmi got %b exp 1", nmi_n); end
        n_tests++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", data_oe); end
        iorq_n = 0; rd_n = 0; addr = 8'h00; #1;
        n_tests++; if (iorq_sys_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys got %b exp 0", iorq_sys_n); end
        iorq_n = 1; rd_n = 1;
        @(negedge clk); reset = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            reg_rd(3'(i));
            e = (i == 2 && !DATA_EN) ? 8'hFF : 8'h00;
            n_tests++; if (obs_rd !== e) begin n_fail++; $display("FAIL reset_reg%0d got %h exp %h", i, obs_rd, e); end
        end
    endtask

    task automatic test_window_capture();
        reg_wr(4, 8'h00); reg_wr(5, 8'h40); reg_wr(6, 8'hF0); reg_wr(7, 8'h01);
        io_wr(8'h4A, 8'h55);
        n_tests++; if (obs_sys_pre !== 1'b1 || obs_sys_post !== 1'b1) begin
            n_fail++; $display("FAIL cap_suppress got %b/%b exp 1/1", obs_sys_pre, obs_sys_post); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_tests++; if (nmi_n !== (k > 4)) begin
                n_fail++; $display("FAIL cap_nmi_k%0d got %b exp %b", k, nmi_n, k > 4); end
        end
        reg_rd(0);
        n_tests++; if (obs_rd !== 8'hA0) begin n_fail++; $display("FAIL cap_status got %h exp a0", obs_rd); end
        n_tests++; if (obs_oe !== 1'b1) begin n_fail++; $display("FAIL cap_oe got %b exp 1", obs_oe); end
        reg_rd(1);
        n_tests++; if (obs_rd !== 8'h4A) begin n_fail++; $display("FAIL cap_addr got %h exp 4a", obs_rd); end
        reg_rd(2);
        n_tests++; if (obs_rd !== (DATA_EN ? 8'h55 : 8'hFF)) begin
            n_fail++; $display("FAIL cap_data got %h exp %h", obs_rd, DATA_EN ? 8'h55 : 8'hFF); end
        reg_wr(3, 8'h00);
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h00) begin n_fail++; $display("FAIL cap_drain got %h exp 00", obs_rd); end
    endtask

    task automatic test_nonmatching();
        io_rd(8'h80);
        n_tests++; if (obs_sys_pre !== 1'b0 || obs_sys_post !== 1'b0) begin
            n_fail++; $display("FAIL nomatch_sys got %b/%b exp 0/0", obs_sys_pre, obs_sys_post); end
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h00) begin n_fail++; $display("FAIL nomatch_count got %h exp 00", obs_rd); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++; if (nmi_n !== 1'b1) begin n_fail++; $display("FAIL nomatch_nmi got %b exp 1", nmi_n); end
        end
    endtask

    task automatic test_iack();
        bus(0, 0, 0, 8'h40, 3'd0, 8'h00);
        n_tests++; if (obs_sys_pre !== 1'b0) begin n_fail++; $display("FAIL iack_sys got %b exp 0", obs_sys_pre); end
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h00) begin n_fail++; $display("FAIL iack_count got %h exp 00", obs_rd); end
    endtask

    task automatic test_full_fifo();
        for (int k = 0; k < 5; k++) begin
            io_wr(8'(8'h41 + k), 8'(8'h10 + k));
            n_tests++; if (obs_sys_pre !== 1'b1) begin n_fail++; $display("FAIL full_sys%0d got %b exp 1", k, obs_sys_pre); end
        end
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h04) begin n_fail++; $display("FAIL full_count got %h exp 04", obs_rd); end
        reg_rd(0);
        n_tests++; if (obs_rd !== 8'hE0) begin n_fail++; $display("FAIL full_ovf got %h exp e0", obs_rd); end
        reg_wr(0, 8'($urandom));
        reg_rd(0);
        n_tests++; if (obs_rd !== 8'hA0) begin n_fail++; $display("FAIL full_ovf_clr got %h exp a0", obs_rd); end
        for (int k = 0; k < 4; k++) begin
            reg_rd(1);
            n_tests++; if (obs_rd !== 8'(8'h41 + k)) begin
                n_fail++; $display("FAIL full_order%0d got %h exp %h", k, obs_rd, 8'(8'h41 + k)); end
            reg_wr(3, 8'h00);
        end
        reg_wr(3, 8'h00);
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h00) begin n_fail++; $display("FAIL full_empty got %h exp 00", obs_rd); end
        repeat (3) @(negedge clk);
        n_tests++; if (nmi_n !== 1'b1) begin n_fail++; $display("FAIL full_nmi_idle got %b exp 1", nmi_n); end
    endtask

    task automatic test_nmi_rearm();
        io_wr(8'h42, 8'h01);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_tests++; if (nmi_n !== (k > 4)) begin n_fail++; $display("FAIL rearm1_k%0d got %b exp %b", k, nmi_n, k > 4); end
        end
        io_wr(8'h43, 8'h02);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++; if (nmi_n !== 1'b1) begin n_fail++; $display("FAIL rearm_armed_k%0d got %b exp 1", k, nmi_n); end
        end
        reg_wr(3, 8'h00); reg_wr(3, 8'h00);
        repeat (3) @(negedge clk);
        io_wr(8'h44, 8'h03);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_tests++; if (nmi_n !== (k > 4)) begin n_fail++; $display("FAIL rearm2_k%0d got %b exp %b", k, nmi_n, k > 4); end
        end
        reg_wr(3, 8'h00);
    endtask

    task automatic test_pop_capture_full();
        for (int k = 0; k < 4; k++) io_wr(8'(8'h41 + k), 8'h00);
        reg_wr(3, 8'h00);
        io_wr(8'h4F, 8'hC3);
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h04) begin n_fail++; $display("FAIL popcap_count got %h exp 04", obs_rd); end
        reg_rd(0);
        n_tests++; if (obs_rd !== 8'hA0) begin n_fail++; $display("FAIL popcap_status got %h exp a0", obs_rd); end
        for (int k = 0; k < 3; k++) reg_wr(3, 8'h00);
        reg_rd(1);
        n_tests++; if (obs_rd !== 8'h4F) begin n_fail++; $display("FAIL popcap_tail got %h exp 4f", obs_rd); end
        reg_wr(3, 8'h00);
    endtask

    task automatic test_priority();
        reg_wr(4, 8'h00); reg_wr(5, 8'h30); reg_wr(6, 8'hF0);
        reg_wr(4, 8'h01); reg_wr(5, 8'h3C); reg_wr(6, 8'hFF);
        reg_wr(4, 8'h03);
        reg_rd(4);
        n_tests++; if (obs_rd !== 8'h01) begin n_fail++; $display("FAIL prio_ptr_ignore got %h exp 01", obs_rd); end
        reg_rd(5);
        n_tests++; if (obs_rd !== 8'h3C) begin n_fail++; $display("FAIL prio_base1 got %h exp 3c", obs_rd); end
        reg_wr(7, 8'h03);
        io_rd(8'h3C);
        reg_rd(0);
        n_tests++; if (obs_rd !== 8'h80) begin n_fail++; $display("FAIL prio_win0 got %h exp 80", obs_rd); end
        reg_rd(2);
        n_tests++; if (obs_rd !== 8'hFF) begin n_fail++; $display("FAIL prio_rd_data got %h exp ff", obs_rd); end
        reg_wr(3, 8'h00);
        reg_wr(7, 8'h02);
        io_wr(8'h3C, 8'h77);
        reg_rd(0);
        n_tests++; if (obs_rd !== 8'hA8) begin n_fail++; $display("FAIL prio_win1 got %h exp a8", obs_rd); end
        reg_wr(3, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < NW; i++) begin
            reg_wr(4, 8'(i)); reg_wr(5, 8'($urandom)); reg_wr(6, 8'($urandom) & 8'hF3);
        end
        reg_wr(7, 8'h03);
        for (int n = 0; n < 300; n++) begin
            int op;
            logic [7:0] a;
            op = $urandom_range(0, 9);
            a  = 8'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                int w;
                w = $urandom_range(0, NW - 1);
                a = (m_base[w] & m_mask[w]) | (a & ~m_mask[w]);
            end
            case (op)
                0, 1, 2: io_wr(a, 8'($urandom));
                3, 4:    io_rd(a);
                5:       reg_rd(3'($urandom));
                6:       reg_wr(3, 8'h00);
                7:       reg_wr(3'($urandom_range(0, 7)), 8'($urandom));
                8:       bus(0, 0, 0, a, 3'd0, 8'h00);
                default: reg_wr(0, 8'h00);
            endcase
            n_tests++; if (obs_sys_pre !== exp_sys_pre || obs_sys_post !== exp_sys_post) begin
                n_fail++; $display("FAIL rnd_sys op%0d got %b/%b exp %b/%b", n, obs_sys_pre, obs_sys_post, exp_sys_pre, exp_sys_post); end
            n_tests++; if (obs_oe !== exp_oe) begin
                n_fail++; $display("FAIL rnd_oe op%0d got %b exp %b", n, obs_oe, exp_oe); end
            n_tests++; if (obs_nmi !== exp_nmi) begin
                n_fail++; $display("FAIL rnd_nmi op%0d got %b exp %b", n, obs_nmi, exp_nmi); end
            if (op == 5) begin
                n_tests++; if (obs_rd !== exp_rd) begin
                    n_fail++; $display("FAIL rnd_rd op%0d reg%0d got %h exp %h", n, lo_addr, obs_rd, exp_rd); end
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                n_tests++; if (nmi_n !== m_nmi_n) begin
                    n_fail++; $display("FAIL rnd_nmi_gap op%0d got %b exp %b", n, nmi_n, m_nmi_n); end
            end
        end
        for (int r = 0; r < 8; r++) begin
            reg_rd(3'(r));
            n_tests++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_final reg%0d got %h exp %h", r, obs_rd, exp_rd); end
        end
    endtask

    task automatic test_reset_in_pulse();
        reg_wr(4, 8'h00); reg_wr(5, 8'h40); reg_wr(6, 8'hF0); reg_wr(7, 8'h01);
        for (int k = 0; k < D; k++) reg_wr(3, 8'h00);
        repeat (4) @(negedge clk);
        io_wr(8'h45, 8'h99);
        @(negedge clk);
        n_tests++; if (nmi_n !== 1'b0) begin n_fail++; $display("FAIL rstp_pulse got %b exp 0", nmi_n); end
        #2 reset = 1;
        #1;
        n_tests++; if (nmi_n !== 1'b1) begin n_fail++; $display("FAIL rstp_nmi got %b exp 1", nmi_n); end
        @(negedge clk); reset = 0;
        reg_rd(3);
        n_tests++; if (obs_rd !== 8'h00) begin n_fail++; $display("FAIL rstp_count got %h exp 00", obs_rd); end
        reg_rd(7);
        n_tests++; if (obs_rd !== 8'h00) begin n_fail++; $display("FAIL rstp_enable got %h exp 00", obs_rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog tests_run %0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_window_capture();
        test_nonmatching();
        test_iack();
        test_full_fifo();
        test_nmi_rearm();
        test_pop_capture_full();
        test_priority();
        test_random();
        test_reset_in_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
